chip_ctrl: RTL
==============

# chip_ctrl

- Top-level sequencer for the convolution datapath: input shift stage, kernel stage, 36-lane MAC array and output stage.
- Runs the full loop nest (output row, output column, output channel, input-channel group). It streams kernel and input beats over the three 16-bit connections and issues every stage control strobe.
- It turns the connections around to drive each finished result out, and reports the output coordinates with that result.

## Interface
Parameters:
- FEATURE_MAP_WIDTH, 1024, output columns
- FEATURE_MAP_HEIGHT, 1024, output rows
- INPUT_NB_CHANNELS, 64, input channels; must be a multiple of 4
- OUTPUT_NB_CHANNELS, 64, output channels
- MAC_LATENCY, 2, cycles from the last input beat to a valid MAC result; must be at least 1

Ports:
- clk  in  1  clock
- arst_n_in  in  1  reset; one clock, reset is synchronous and active-low
- start  in  1  start a full layer
- running  out  1  high from the cycle after start is accepted until the last result has been driven
- con_1_valid, con_2_valid, con_3_valid  in  1 each  upstream data valid
- con_1_ready, con_2_ready, con_3_ready  out  1 each  all three are identical
- driving_cons  out  1  chip drives con_1..3
- ctrl_KDS_LE_select  out  1  kernel stage load enable
- ctrl_IDSS_LE_select, ctrl_IDSS_shift  out  1 each  input stage load and shift
- ctrl_MAC_clear  out  1  MAC accumulator restarts from zero
- ctrl_ODS_shift, ctrl_ODS_sel_out  out  1 each  output stage capture and drive select
- output_valid  out  1  result on the connections this cycle
- output_x  out  clog2(FEATURE_MAP_WIDTH)  column of the result
- output_y  out  clog2(FEATURE_MAP_HEIGHT)  row of the result
- output_ch  out  clog2(OUTPUT_NB_CHANNELS)  channel of the result

## Operation
- States: IDLE, LOAD_K, LOAD_I, COMPUTE, OUT.
- Beat definition: a beat is accepted when ready is high and all three valids are high. Partial valids are never accepted.
- No timeout: the FSM waits indefinitely for beats.
- IDLE: all strobes low. start=1 moves to LOAD_K and clears all counters.
- LOAD_K: ready=1. Each beat pulses ctrl_KDS_LE_select in the same cycle.
  - After 12 beats (36 weights = 3x3 kernel x 4 input channels), go to LOAD_I.
- LOAD_I: ready=1. Each beat pulses ctrl_IDSS_LE_select and ctrl_IDSS_shift together.
  - After 12 beats, go to COMPUTE.
- COMPUTE: ready=0. Stays for MAC_LATENCY cycles.
  - ctrl_MAC_clear is high in the first COMPUTE cycle only when the input-channel group counter is 0.
  - On the last cycle: if the group is the last (INPUT_NB_CHANNELS/4-1), pulse ctrl_ODS_shift and go to OUT.
  - Otherwise increment the group counter and go to LOAD_K.
- OUT: lasts one cycle. driving_cons, ctrl_ODS_sel_out and output_valid are all 1; output_x/y/ch carry the current counters.
  - Then reset the group counter and advance the nest: ch innermost, then x, then y.
  - If ch, x and y were all at their maximum, go to IDLE; otherwise go to LOAD_K.
- Counter rules: each counter wraps to 0 and carries into the next one when it hits max-1. The counters are unsigned and exactly wide enough for their range.
- start is ignored while running=1.
- driving_cons is high only in OUT, and ready is low whenever driving_cons is high. Both directions are never active in the same cycle.

## Timing
- Reset: the FSM goes to IDLE and all counters clear. Every output is 0, including running, ready, driving_cons, all strobes, output_valid and the coordinates.
- Reset mid-operation: the state is abandoned. Outputs are 0 on the cycle after the reset edge.
- All outputs are Moore and registered, except the beat-qualified strobes (KDS/IDSS LE, IDSS shift). Those are combinational from valid & ready & state.
- running rises one cycle after start is sampled. It falls in the cycle after the final OUT.
- Stall-free cost per input-channel group is 24+MAC_LATENCY cycles. Each result adds 1 OUT cycle.

## Configuration
- CHIP_CTRL_PERF_CNT_EN:
  - Defined: adds output stall_cycles (32 bits). It counts cycles in LOAD_K/LOAD_I with ready=1 and no beat, saturates at all-ones, and clears on start.
  - Undefined: the port and counter do not exist.

## Structure
- Package chip_ctrl_pkg holds:
  - the state enum ctrl_state_t;
  - CH_PER_PASS=4 and BEATS_PER_LOAD=12.
- Sub-module loop_counter, instantiated four times and chained by wrap flags:
  - parameter MAX;
  - inputs inc and clr;
  - outputs count and last.

## Test plan
- Single result (4x4 map reduced to 1x1, in=4, out=1, MAC_LATENCY=2): start, then 24 beats with valids held high -> exactly one output_valid at cycle 27 after start; running falls the next cycle.
- Multi-group (in=8): two LOAD_K/LOAD_I/COMPUTE rounds -> ctrl_MAC_clear only in the first round, ctrl_ODS_shift only in the second.
- Coordinate order (2x2 map, out=2): -> 8 output_valid pulses with (y,x,ch) = (0,0,0),(0,0,1),(0,1,0) ... (1,1,1).
- Backpressure: drop con_2_valid for 5 cycles mid LOAD_K -> no LE pulses in those cycles, the beat count is unchanged, and stall_cycles=5 when the macro is defined.
- Reset at cycle 10 of LOAD_I -> next cycle all outputs 0 and state IDLE; a fresh start then yields the full, correct sequence.
- start held high across the whole run -> no restart; a single layer completes.

Source files
------------

// File: rtl/chip_ctrl_pkg.sv
// chip_ctrl_pkg: sequencer states, per-pass constants and counter width helper
package chip_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    LOAD_I,
    COMPUTE,
    OUT
  } ctrl_state_t;

  localparam int CH_PER_PASS    = 4;
  localparam int BEATS_PER_LOAD = 12;

  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chip_ctrl_loop_counter.sv
// loop_counter: one loop-nest level counting 0..MAX-1, last flags chain the levels
module loop_counter import chip_ctrl_pkg::*; #(
  parameter int MAX = 4
) (
  input  logic                      clk,
  input  logic                      arst_n_in,
  input  logic                      inc,
  input  logic                      clr,
  output logic [cnt_width(MAX)-1:0] count,
  output logic                      last
);

  localparam int W = cnt_width(MAX);

  logic [W-1:0] count_q, count_d;

  assign last    = count_q == W'(MAX - 1);
  assign count   = count_q;
  assign count_d = clr ? '0 : inc ? (last ? '0 : count_q + 1'b1) : count_q;

  // wrap at MAX-1, clear has priority over increment
  always_ff @(posedge clk) begin
    if (!arst_n_in) count_q <= '0;
    else count_q <= count_d;
  end

endmodule

// File: rtl/chip_ctrl.sv
// chip_ctrl: convolution loop-nest sequencer; CHIP_CTRL_PERF_CNT_EN adds a stall_cycles counter
module chip_ctrl import chip_ctrl_pkg::*; #(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int MAC_LATENCY        = 2
) (
  input  logic                                      clk,
  input  logic                                      arst_n_in,
  input  logic                                      start,
  output logic                                      running,
  input  logic                                      con_1_valid,
  input  logic                                      con_2_valid,
  input  logic                                      con_3_valid,
  output logic                                      con_1_ready,
  output logic                                      con_2_ready,
  output logic                                      con_3_ready,
  output logic                                      driving_cons,
  output logic                                      ctrl_KDS_LE_select,
  output logic                                      ctrl_IDSS_LE_select,
  output logic                                      ctrl_IDSS_shift,
  output logic                                      ctrl_MAC_clear,
  output logic                                      ctrl_ODS_shift,
  output logic                                      ctrl_ODS_sel_out,
  output logic                                      output_valid,
  output logic [cnt_width(FEATURE_MAP_WIDTH)-1:0]   output_x,
  output logic [cnt_width(FEATURE_MAP_HEIGHT)-1:0]  output_y,
  output logic [cnt_width(OUTPUT_NB_CHANNELS)-1:0]  output_ch
`ifdef CHIP_CTRL_PERF_CNT_EN
  ,output logic [31:0]                              stall_cycles
`endif
);

  localparam int GROUPS = INPUT_NB_CHANNELS / CH_PER_PASS;
  localparam int XW     = cnt_width(FEATURE_MAP_WIDTH);
  localparam int YW     = cnt_width(FEATURE_MAP_HEIGHT);
  localparam int CHW    = cnt_width(OUTPUT_NB_CHANNELS);
  localparam int GW     = cnt_width(GROUPS);
  localparam int CW     = cnt_width(BEATS_PER_LOAD > MAC_LATENCY ? BEATS_PER_LOAD : MAC_LATENCY);

  ctrl_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           running_q, ready_q, driving_q, mac_clear_q, ods_shift_q;
  logic [XW-1:0]  out_x_q, x_cnt;
  logic [YW-1:0]  out_y_q, y_cnt;
  logic [CHW-1:0] out_ch_q, ch_cnt;
  logic [GW-1:0]  grp_cnt;
  logic           grp_last, ch_last, x_last, y_last;
  logic           all_valid, beat, start_acc, k_done, i_done, c_done, in_out;

  assign all_valid = con_1_valid & con_2_valid & con_3_valid;
  assign beat      = all_valid & ready_q;
  assign start_acc = state_q == IDLE && start;
  assign k_done    = state_q == LOAD_K && beat && cnt_q == CW'(BEATS_PER_LOAD - 1);
  assign i_done    = state_q == LOAD_I && beat && cnt_q == CW'(BEATS_PER_LOAD - 1);
  assign c_done    = state_q == COMPUTE && cnt_q == CW'(MAC_LATENCY - 1);
  assign in_out    = state_q == OUT;

  assign running             = running_q;
  assign con_1_ready         = ready_q;
  assign con_2_ready         = ready_q;
  assign con_3_ready         = ready_q;
  assign driving_cons        = driving_q;
  assign ctrl_ODS_sel_out    = driving_q;
  assign output_valid        = driving_q;
  assign ctrl_MAC_clear      = mac_clear_q;
  assign ctrl_ODS_shift      = ods_shift_q;
  assign ctrl_KDS_LE_select  = beat && state_q == LOAD_K;
  assign ctrl_IDSS_LE_select = beat && state_q == LOAD_I;
  assign ctrl_IDSS_shift     = beat && state_q == LOAD_I;
  assign output_x            = out_x_q;
  assign output_y            = out_y_q;
  assign output_ch           = out_ch_q;

  loop_counter #(.MAX(GROUPS)) u_grp (
    .clk(clk), .arst_n_in(arst_n_in), .inc(c_done && !grp_last), .clr(start_acc || in_out),
    .count(grp_cnt), .last(grp_last)
  );

  loop_counter #(.MAX(OUTPUT_NB_CHANNELS)) u_ch (
    .clk(clk), .arst_n_in(arst_n_in), .inc(in_out), .clr(start_acc),
    .count(ch_cnt), .last(ch_last)
  );

  loop_counter #(.MAX(FEATURE_MAP_WIDTH)) u_x (
    .clk(clk), .arst_n_in(arst_n_in), .inc(in_out && ch_last), .clr(start_acc),
    .count(x_cnt), .last(x_last)
  );

  loop_counter #(.MAX(FEATURE_MAP_HEIGHT)) u_y (
    .clk(clk), .arst_n_in(arst_n_in), .inc(in_out && ch_last && x_last), .clr(start_acc),
    .count(y_cnt), .last(y_last)
  );

  // phase sequencing; every phase boundary is a state change, which restarts the phase counter
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? LOAD_K : IDLE;
      LOAD_K:  state_d = k_done ? LOAD_I : LOAD_K;
      LOAD_I:  state_d = i_done ? COMPUTE : LOAD_I;
      COMPUTE: state_d = c_done ? (grp_last ? OUT : LOAD_K) : COMPUTE;
      OUT:     state_d = ch_last && x_last && y_last ? IDLE : LOAD_K;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? '0 : cnt_q + CW'(beat || state_q == COMPUTE);
  end

  // state and Moore outputs, all decoded from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      running_q   <= 1'b0;
      ready_q     <= 1'b0;
      driving_q   <= 1'b0;
      mac_clear_q <= 1'b0;
      ods_shift_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      running_q   <= state_d != IDLE;
      ready_q     <= state_d == LOAD_K || state_d == LOAD_I;
      driving_q   <= state_d == OUT;
      mac_clear_q <= state_d == COMPUTE && state_q == LOAD_I && grp_cnt == '0;
      ods_shift_q <= state_d == COMPUTE && cnt_d == CW'(MAC_LATENCY - 1) && grp_last;
      out_x_q     <= state_d == OUT ? x_cnt : '0;
      out_y_q     <= state_d == OUT ? y_cnt : '0;
      out_ch_q    <= state_d == OUT ? ch_cnt : '0;
    end
  end

`ifdef CHIP_CTRL_PERF_CNT_EN
  logic [31:0] stall_q;

  assign stall_cycles = stall_q;

  // saturating count of load cycles the chip was ready but upstream offered no full beat
  always_ff @(posedge clk) begin
    if (!arst_n_in || start_acc) stall_q <= '0;
    else if (ready_q && !all_valid && !(&stall_q)) stall_q <= stall_q + 32'd1;
  end
`endif

endmodule
